// File: rtl/dram_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data DRAM port arbiter.
package dram_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INSTR_RD,
    ST_DATA_RD,
    ST_DATA_WR,
    ST_RESP
  } arb_state_t;

  localparam int unsigned ARB_RR         = 0;
  localparam int unsigned ARB_DATA_FIRST = 1;

  typedef enum logic [1:0] {
    GRANT_NONE  = 2'b00,
    GRANT_INSTR = 2'b01,
    GRANT_DATA  = 2'b10
  } grant_t;

endpackage

// File: rtl/dram_port_arbiter_rr2.sv
// Two-input chooser: round-robin or fixed data priority on conflict,
// with a registered flag remembering which side was served last.
module arb_rr2
  import dram_port_arbiter_pkg::*;
#(
  parameter int unsigned ARB_MODE = ARB_RR
) (
  input  logic clk,
  input  logic rst,
  input  logic req_instr,
  input  logic req_data,
  input  logic update,
  input  logic update_data,
  output logic grant_instr,
  output logic grant_data
);

  logic last_data;

  // Remember the side served by the transaction just completed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_data <= 1'b0;
    end else if (update) begin
      last_data <= update_data;
    end
  end

  // Pick a winner; on conflict, data wins unless it was served last in round-robin mode.
  always_comb begin
    grant_instr = 1'b0;
    grant_data  = 1'b0;
    if (req_instr && req_data) begin
      if ((ARB_MODE == ARB_DATA_FIRST) || !last_data) begin
        grant_data = 1'b1;
      end else begin
        grant_instr = 1'b1;
      end
    end else begin
      grant_instr = req_instr;
      grant_data  = req_data;
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one DRAM between the instruction-fetch port and the data port,
// one transaction at a time, returning results only to the granted side.
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_SIZE  = 256,
  parameter int unsigned ARB_MODE   = ARB_RR
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  instr_read_enable_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_read_valid_o,
  output logic [LINE_SIZE-1:0]  instr_read_data_o,
  input  logic                  data_read_enable_i,
  input  logic                  data_write_enable_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [LINE_SIZE-1:0]  data_write_data_i,
  output logic                  data_read_valid_o,
  output logic                  data_write_valid_o,
  output logic [LINE_SIZE-1:0]  data_read_data_o,
  output logic                  mem_read_enable_o,
  output logic                  mem_write_enable_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [LINE_SIZE-1:0]  mem_write_data_o,
  input  logic                  mem_read_valid_i,
  input  logic                  mem_write_valid_i,
  input  logic [LINE_SIZE-1:0]  mem_read_data_i,
  output logic [1:0]            grant_o
);

  arb_state_t            state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_SIZE-1:0]  wdata_q;
  logic [LINE_SIZE-1:0]  instr_rdata_q;
  logic [LINE_SIZE-1:0]  data_rdata_q;
  logic                  is_write_q;
  grant_t                grant_q;
  logic                  gnt_instr, gnt_data;

  arb_rr2 #(
    .ARB_MODE(ARB_MODE)
  ) u_arb (
    .clk         (clk_i),
    .rst         (rst_i),
    .req_instr   (instr_read_enable_i),
    .req_data    (data_read_enable_i | data_write_enable_i),
    .update      (state == ST_RESP),
    .update_data (grant_q == GRANT_DATA),
    .grant_instr (gnt_instr),
    .grant_data  (gnt_data)
  );

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and DRAM/requester outputs; valids only in RESP.
  always_comb begin
    state_next         = state;
    mem_read_enable_o  = 1'b0;
    mem_write_enable_o = 1'b0;
    instr_read_valid_o = 1'b0;
    data_read_valid_o  = 1'b0;
    data_write_valid_o = 1'b0;
    mem_addr_o         = addr_q;
    mem_write_data_o   = wdata_q;
    instr_read_data_o  = instr_rdata_q;
    data_read_data_o   = data_rdata_q;
    grant_o            = grant_q;
    case (state)
      ST_IDLE: begin
        if (gnt_data) begin
          state_next = data_write_enable_i ? ST_DATA_WR : ST_DATA_RD;
        end else if (gnt_instr) begin
          state_next = ST_INSTR_RD;
        end
      end
      ST_INSTR_RD, ST_DATA_RD: begin
        mem_read_enable_o = 1'b1;
        if (mem_read_valid_i) state_next = ST_RESP;
      end
      ST_DATA_WR: begin
        mem_write_enable_o = 1'b1;
        if (mem_write_valid_i) state_next = ST_RESP;
      end
      ST_RESP: begin
        instr_read_valid_o = (grant_q == GRANT_INSTR);
        data_read_valid_o  = (grant_q == GRANT_DATA) && !is_write_q;
        data_write_valid_o = (grant_q == GRANT_DATA) && is_write_q;
        state_next         = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Latch the granted request and capture returned lines straight into the
  // per-port read-data registers, which then hold until the next read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      is_write_q    <= 1'b0;
      grant_q       <= GRANT_NONE;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_data) begin
            addr_q     <= data_addr_i;
            wdata_q    <= data_write_data_i;
            is_write_q <= data_write_enable_i;
            grant_q    <= GRANT_DATA;
          end else if (gnt_instr) begin
            addr_q     <= instr_addr_i;
            is_write_q <= 1'b0;
            grant_q    <= GRANT_INSTR;
          end
        end
        ST_INSTR_RD: if (mem_read_valid_i) instr_rdata_q <= mem_read_data_i;
        ST_DATA_RD:  if (mem_read_valid_i) data_rdata_q <= mem_read_data_i;
        ST_RESP:     grant_q <= GRANT_NONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Randomized bench: two arbiters (round-robin and data-first), each with its
// own DRAM model, requesters and transaction-level reference model.
`timescale 1ns/1ps
module tb_dram_port_arbiter;

  localparam int AW   = 32;
  localparam int LW   = 256;
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst    [2];
  logic          ien    [2];
  logic [AW-1:0] iaddr  [2];
  logic          drd    [2];
  logic          dwr    [2];
  logic [AW-1:0] daddr  [2];
  logic [LW-1:0] dwdata [2];
  logic          mrv    [2];
  logic          mwv    [2];
  logic [LW-1:0] mrdata [2];
  wire           ivalid  [2];
  wire  [LW-1:0] idata   [2];
  wire           drvalid [2];
  wire           dwvalid [2];
  wire  [LW-1:0] drdata  [2];
  wire           mre     [2];
  wire           mwe     [2];
  wire  [AW-1:0] maddr   [2];
  wire  [LW-1:0] mwdata  [2];
  wire  [1:0]    grant   [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    dram_port_arbiter #(
      .ADDR_WIDTH(AW),
      .LINE_SIZE (LW),
      .ARB_MODE  (k)
    ) u_dut (
      .clk_i               (clk),
      .rst_i               (rst[k]),
      .instr_read_enable_i (ien[k]),
      .instr_addr_i        (iaddr[k]),
      .instr_read_valid_o  (ivalid[k]),
      .instr_read_data_o   (idata[k]),
      .data_read_enable_i  (drd[k]),
      .data_write_enable_i (dwr[k]),
      .data_addr_i         (daddr[k]),
      .data_write_data_i   (dwdata[k]),
      .data_read_valid_o   (drvalid[k]),
      .data_write_valid_o  (dwvalid[k]),
      .data_read_data_o    (drdata[k]),
      .mem_read_enable_o   (mre[k]),
      .mem_write_enable_o  (mwe[k]),
      .mem_addr_o          (maddr[k]),
      .mem_write_data_o    (mwdata[k]),
      .mem_read_valid_i    (mrv[k]),
      .mem_write_valid_i   (mwv[k]),
      .mem_read_data_i     (mrdata[k]),
      .grant_o             (grant[k])
    );
  end

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, act, exp);
    end
  endtask

  // DRAM contents, keyed by {instance, address}
  logic [LW-1:0] mem [logic [32:0]];

  function automatic logic [LW-1:0] mem_rd(input int k, input logic [AW-1:0] a);
    logic [32:0] key;
    logic [31:0] seed;
    key  = {k[0], a};
    seed = a ^ 32'hC0DE_0000;
    if (mem.exists(key)) return mem[key];
    return {8{seed}};
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] x;
    for (int w = 0; w < 8; w++) x[w*32 +: 32] = $urandom();
    return x;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    return AW'($urandom_range(0, 7)) << 5;
  endfunction

  // reference model: one transaction record per instance
  int unsigned   cyc;
  bit            busy [2];
  int unsigned   kind [2];      // 0 instr read, 1 data read, 2 data write
  int unsigned   g    [2];      // first cycle with mem enable high
  int unsigned   lat  [2];
  logic [AW-1:0] m_addr  [2];
  logic [LW-1:0] m_wdata [2];
  bit            last_data [2];
  logic [LW-1:0] exp_idata [2];
  logic [LW-1:0] exp_ddata [2];
  int unsigned   dcnt [2];
  bit i_pend [2], d_rd_pend [2], d_wr_pend [2];
  bit force_instr [2], rst_pend [2], first [2], want_rst [2], do_rst [2];

  task automatic check_zero(input int k, input string why);
    check($sformatf("u%0d %s mem_read_enable", k, why), mre[k], '0);
    check($sformatf("u%0d %s mem_write_enable", k, why), mwe[k], '0);
    check($sformatf("u%0d %s mem_addr", k, why), maddr[k], '0);
    check($sformatf("u%0d %s mem_write_data", k, why), mwdata[k], '0);
    check($sformatf("u%0d %s grant", k, why), grant[k], '0);
    check($sformatf("u%0d %s valids", k, why), {ivalid[k], drvalid[k], dwvalid[k]}, '0);
    check($sformatf("u%0d %s instr_data", k, why), idata[k], '0);
    check($sformatf("u%0d %s data_data", k, why), drdata[k], '0);
  endtask

  task automatic step(input int k);
    logic        e_mre, e_mwe, e_iv, e_drv, e_dwv;
    logic [1:0]  e_gnt;
    int unsigned p_i, p_d, dc;
    bit          ir, win_d;

    if (rst_pend[k]) begin
      check_zero(k, "reset_held");
      rst[k] = 1'b0; rst_pend[k] = 1'b0; busy[k] = 1'b0; last_data[k] = 1'b0;
      exp_idata[k] = '0; exp_ddata[k] = '0; dcnt[k] = 0;
      i_pend[k] = 1'b0; d_rd_pend[k] = 1'b0; d_wr_pend[k] = 1'b0;
      force_instr[k] = 1'b1; first[k] = 1'b1;
    end

    // expected outputs this cycle from the transaction timeline
    e_mre = 1'b0; e_mwe = 1'b0; e_iv = 1'b0; e_drv = 1'b0; e_dwv = 1'b0; e_gnt = 2'b00;
    if (busy[k]) begin
      if (cyc == g[k] + lat[k] + 2) begin
        busy[k] = 1'b0;
      end else begin
        e_gnt = (kind[k] == 0) ? 2'b01 : 2'b10;
        if (cyc <= g[k] + lat[k]) begin
          e_mre = (kind[k] != 2);
          e_mwe = (kind[k] == 2);
        end else begin
          e_iv  = (kind[k] == 0);
          e_drv = (kind[k] == 1);
          e_dwv = (kind[k] == 2);
          if (kind[k] == 0) exp_idata[k] = mem_rd(k, m_addr[k]);
          if (kind[k] == 1) exp_ddata[k] = mem_rd(k, m_addr[k]);
        end
      end
    end

    check($sformatf("u%0d c%0d mem_read_enable", k, cyc), mre[k], e_mre);
    check($sformatf("u%0d c%0d mem_write_enable", k, cyc), mwe[k], e_mwe);
    if (e_mre || e_mwe) check($sformatf("u%0d c%0d mem_addr", k, cyc), maddr[k], m_addr[k]);
    if (e_mwe) check($sformatf("u%0d c%0d mem_write_data", k, cyc), mwdata[k], m_wdata[k]);
    check($sformatf("u%0d c%0d grant", k, cyc), grant[k], e_gnt);
    check($sformatf("u%0d c%0d instr_valid", k, cyc), ivalid[k], e_iv);
    check($sformatf("u%0d c%0d data_read_valid", k, cyc), drvalid[k], e_drv);
    check($sformatf("u%0d c%0d data_write_valid", k, cyc), dwvalid[k], e_dwv);
    check($sformatf("u%0d c%0d instr_data", k, cyc), idata[k], exp_idata[k]);
    check($sformatf("u%0d c%0d data_data", k, cyc), drdata[k], exp_ddata[k]);

    // requesters release on their own valid pulse
    if (ivalid[k])  i_pend[k] = 1'b0;
    if (drvalid[k]) d_rd_pend[k] = 1'b0;
    if (dwvalid[k]) d_wr_pend[k] = 1'b0;

    // DRAM: respond after lat cycles of enable, plus stray non-matching valids
    mrv[k] = 1'b0;
    mwv[k] = 1'b0;
    if (mre[k] || mwe[k]) begin
      dcnt[k]++;
      if (dcnt[k] == lat[k] + 1) begin
        if (mre[k]) begin
          mrv[k] = 1'b1;
          mrdata[k] = mem_rd(k, maddr[k]);
        end else begin
          mwv[k] = 1'b1;
          mem[{k[0], maddr[k]}] = mwdata[k];
        end
      end else if ($urandom_range(0, 7) == 0) begin
        if (mre[k]) mwv[k] = 1'b1;
        else begin mrv[k] = 1'b1; mrdata[k] = rnd_line(); end
      end
    end else begin
      dcnt[k] = 0;
      if ($urandom_range(0, 7) == 0) begin
        mrv[k] = 1'($urandom_range(0, 1));
        mwv[k] = 1'($urandom_range(0, 1));
        mrdata[k] = rnd_line();
      end
    end

    if (want_rst[k] && busy[k] && kind[k] == 1 && cyc == g[k] + 2) begin
      want_rst[k] = 1'b0;
      do_rst[k] = 1'b1;
      return;
    end

    // requester stimulus
    if (cyc < 60) p_i = 0;
    else if (cyc >= 1500 && cyc < 2500) p_i = 95;
    else p_i = 35;
    p_d = p_i;
    if (force_instr[k]) begin
      force_instr[k] = 1'b0; i_pend[k] = 1'b1; iaddr[k] = 32'h40;
    end else if (!i_pend[k] && $urandom_range(0, 99) < p_i) begin
      i_pend[k] = 1'b1; iaddr[k] = rnd_addr();
    end
    if (cyc == 20) begin
      d_wr_pend[k] = 1'b1; d_rd_pend[k] = 1'b1;
      daddr[k] = 32'h80; dwdata[k] = {32{8'hA5}};
    end else if (!d_rd_pend[k] && !d_wr_pend[k] && $urandom_range(0, 99) < p_d) begin
      dc = $urandom_range(0, 2);
      d_rd_pend[k] = (dc != 1);
      d_wr_pend[k] = (dc != 0);
      daddr[k] = rnd_addr();
      dwdata[k] = rnd_line();
    end
    ien[k] = i_pend[k];
    drd[k] = d_rd_pend[k];
    dwr[k] = d_wr_pend[k];

    // arbitration rules applied to the requests seen in an idle cycle
    if (!busy[k]) begin
      ir = ien[k];
      dc = dwr[k] ? 2 : (drd[k] ? 1 : 0);
      if (ir || dc != 0) begin
        win_d = (dc != 0) && (!ir || k == 1 || !last_data[k]);
        busy[k] = 1'b1;
        g[k] = cyc + 1;
        kind[k] = win_d ? dc : 0;
        if (first[k]) lat[k] = 10;
        else if (want_rst[k] && kind[k] == 1) lat[k] = 8;
        else lat[k] = $urandom_range(0, 5);
        first[k] = 1'b0;
        m_addr[k] = win_d ? daddr[k] : iaddr[k];
        m_wdata[k] = dwdata[k];
        last_data[k] = win_d;
      end
    end
  endtask

  initial begin
    bit any;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; rst_pend[k] = 1'b1;
      ien[k] = 1'b0; iaddr[k] = '0; drd[k] = 1'b0; dwr[k] = 1'b0;
      daddr[k] = '0; dwdata[k] = '0; mrv[k] = 1'b0; mwv[k] = 1'b0; mrdata[k] = '0;
      want_rst[k] = 1'b0; do_rst[k] = 1'b0; lat[k] = 0;
    end
    repeat (2) @(posedge clk);
    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 2600) begin want_rst[0] = 1'b1; want_rst[1] = 1'b1; end
      for (int k = 0; k < 2; k++) step(k);
      any = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (do_rst[k]) begin
          rst[k] = 1'b1; rst_pend[k] = 1'b1;
          ien[k] = 1'b0; drd[k] = 1'b0; dwr[k] = 1'b0; mrv[k] = 1'b0; mwv[k] = 1'b0;
          any = 1'b1;
        end
      end
      if (any) begin
        #1;
        for (int k = 0; k < 2; k++) begin
          if (do_rst[k]) begin
            check_zero(k, "reset_async");
            do_rst[k] = 1'b0;
          end
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
